// File: rtl/spram_result_reader.sv
// rtl/spram_result_reader.sv - streams complex results out of the real/imag result RAMs (option: READER_CHKSUM_EN)
module spram_result_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_q_real,
    input  logic [DATA_WIDTH-1:0] ram_q_imag,
    output logic [DATA_WIDTH-1:0] out_real,
    output logic [DATA_WIDTH-1:0] out_imag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
`ifdef READER_CHKSUM_EN
    output logic [DATA_WIDTH-1:0] chksum,
`endif
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                  state;
    state_t                  state_next;

    // Read sequencing
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [ADDR_WIDTH:0]     remaining;
    logic                    inflight;
    logic                    inflight_last;
    logic                    issue;
    logic                    issue_last;
    logic [ADDR_WIDTH-1:0]   issue_addr;
    logic                    start_accept;
    logic [2:0]              committed;

    // Two-entry output FIFO
    logic [DATA_WIDTH-1:0]   fifo_real [2];
    logic [DATA_WIDTH-1:0]   fifo_imag [2];
    logic                    fifo_last [2];
    logic                    wr_idx;
    logic                    rd_idx;
    logic [1:0]              occ;
    logic                    push;
    logic                    pop;

    logic                    done_q;

    assign push      = inflight;
    assign out_valid = (occ != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_real  = fifo_real[rd_idx];
    assign out_imag  = fifo_imag[rd_idx];
    assign out_last  = fifo_last[rd_idx];
    assign busy      = (state == S_RUN);
    assign done      = done_q;

    // FIFO slots still spoken for after this cycle's pop; a new read may only
    // be issued if its data is guaranteed a slot when it returns.
    assign committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    // The address port follows the issuing pointer and otherwise holds.
    assign ram_addr  = issue ? issue_addr : addr_q;

    // Next-state and read-issue decisions.
    always_comb begin
        state_next   = state;
        issue        = 1'b0;
        issue_last   = 1'b0;
        issue_addr   = rd_ptr;
        start_accept = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    if (count == '0) begin
                        state_next = S_FINISH;
                    end else begin
                        // First read goes out in the start cycle itself so the
                        // first beat appears two cycles later.
                        state_next = S_RUN;
                        issue      = 1'b1;
                        issue_addr = base_addr;
                        issue_last = (count == CNT_ONE);
                    end
                end
            end
            S_RUN: begin
                if ((remaining != '0) && (committed < 3'd2)) begin
                    issue      = 1'b1;
                    issue_last = (remaining == CNT_ONE);
                end
                // Leave as the final beat is accepted so done lands in the next cycle.
                if ((remaining == '0) && !inflight &&
                    ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
                    state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register, read pointer, remaining count and in-flight tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            rd_ptr        <= '0;
            addr_q        <= '0;
            remaining     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            state         <= state_next;
            addr_q        <= ram_addr;
            inflight      <= issue;
            inflight_last <= issue_last;
            if (issue) begin
                rd_ptr <= issue_addr + ADDR_ONE;
            end
            if (start_accept) begin
                remaining <= count - {{ADDR_WIDTH{1'b0}}, issue};
            end else if (issue) begin
                remaining <= remaining - CNT_ONE;
            end
        end
    end

    // Output FIFO: RAM data is pushed the cycle after its read was issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_real[0] <= '0;
            fifo_real[1] <= '0;
            fifo_imag[0] <= '0;
            fifo_imag[1] <= '0;
            fifo_last[0] <= 1'b0;
            fifo_last[1] <= 1'b0;
            wr_idx       <= 1'b0;
            rd_idx       <= 1'b0;
            occ          <= 2'd0;
        end else begin
            if (push) begin
                fifo_real[wr_idx] <= ram_q_real;
                fifo_imag[wr_idx] <= ram_q_imag;
                fifo_last[wr_idx] <= inflight_last;
                wr_idx            <= ~wr_idx;
            end
            if (pop) begin
                rd_idx <= ~rd_idx;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    // Done pulse: raised on acceptance of the final beat, or by FINISH itself
    // when nothing was streamed (count of zero).
    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= ((state == S_RUN) && (state_next == S_FINISH) && pop) ||
                      ((state == S_FINISH) && !done_q);
        end
    end

`ifdef READER_CHKSUM_EN
    // Running XOR of real^imag over accepted beats, restarted by each accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            chksum <= '0;
        end else if (start_accept) begin
            chksum <= '0;
        end else if (pop) begin
            chksum <= chksum ^ out_real ^ out_imag;
        end
    end
`else
    // Without the checksum option accepted beats only advance the FIFO.
`endif

endmodule

// File: tb/tb_spram_result_reader.sv
// tb/tb_spram_result_reader.sv - self-checking bench for spram_result_reader
module tb_spram_result_reader;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_q_real;
    logic [DW-1:0] ram_q_imag;
    logic [DW-1:0] out_real;
    logic [DW-1:0] out_imag;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic          done;
`ifdef READER_CHKSUM_EN
    logic [DW-1:0] chksum;
`endif

    always #5 clk = ~clk;

    spram_result_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .count      (count),
        .ram_addr   (ram_addr),
        .ram_q_real (ram_q_real),
        .ram_q_imag (ram_q_imag),
        .out_real   (out_real),
        .out_imag   (out_imag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
`ifdef READER_CHKSUM_EN
        .chksum     (chksum),
`endif
        .done       (done)
    );

    // Result RAMs with one cycle of synchronous read latency
    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] mem_i [DEPTH];
    always @(posedge clk) begin
        ram_q_real <= mem_r[ram_addr];
        ram_q_imag <= mem_i[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          last;
    } beat_t;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model of the command in progress
    beat_t         exp_q[$];
    int            m_busy_from = -1;
    int            m_done_cyc  = -1;
    bit            m_busy      = 1'b0;
    logic [DW-1:0] m_chk       = '0;
    bit            done_seen   = 1'b0;
    int            done_seen_cyc = -1;
    logic [DW-1:0] log_re[$];
    logic [DW-1:0] log_im[$];
    int            log_cyc[$];
    bit            trace_on = 1'b0;
    logic [AW-1:0] addr_log[$];
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_re, prev_im;
    logic          prev_last;

    bit            pat_mode = 1'b0;
    int            pat_base = 0;
    bit            pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, required 0x%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Compare process: checks the DUT against the model every cycle, mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (cyc == m_busy_from) m_busy = 1'b1;
            if (cyc == m_done_cyc)  m_busy = 1'b0;
            chk(busy == m_busy, "busy", 32'(busy), 32'(m_busy));
            chk(done == (cyc == m_done_cyc), "done", 32'(done), 32'(cyc == m_done_cyc));
            if (done) begin
                done_seen     = 1'b1;
                done_seen_cyc = cyc;
            end
`ifdef READER_CHKSUM_EN
            if (cyc == m_done_cyc) chk(chksum == m_chk, "chksum", chksum, m_chk);
`endif
            if (prev_stall) begin
                chk(out_valid && out_real == prev_re && out_imag == prev_im && out_last == prev_last,
                    "hold_while_stalled", out_real, prev_re);
            end
            if (exp_q.size() == 0) begin
                chk(!out_valid, "no_extra_beat", 32'(out_valid), 32'd0);
            end else if (out_valid) begin
                chk(out_real == exp_q[0].re, "out_real", out_real, exp_q[0].re);
                chk(out_imag == exp_q[0].im, "out_imag", out_imag, exp_q[0].im);
                chk(out_last == exp_q[0].last, "out_last", 32'(out_last), 32'(exp_q[0].last));
                if (out_ready) begin
                    log_re.push_back(out_real);
                    log_im.push_back(out_imag);
                    log_cyc.push_back(cyc);
                    m_chk = m_chk ^ exp_q[0].re ^ exp_q[0].im;
                    if (exp_q[0].last) m_done_cyc = cyc + 1;
                    void'(exp_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_re    = out_real;
            prev_im    = out_imag;
            prev_last  = out_last;
            if (trace_on && (addr_log.size() == 0 || addr_log[addr_log.size()-1] != ram_addr))
                addr_log.push_back(ram_addr);
        end
    end

    // Downstream ready: always high, or a repeating 1,0,0,1,0,1 pattern
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = pat_mode ? pat[(cyc - pat_base) % 6] : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] = 32'(i) << 21;
            mem_i[i] = -(32'(i) << 21);
        end
    endtask

    task automatic launch(input logic [AW-1:0] b, input logic [AW:0] n, output int s);
        beat_t e;
        start     = 1'b1;
        base_addr = b;
        count     = n;
        s         = cyc;
        exp_q.delete();
        log_re.delete();
        log_im.delete();
        log_cyc.delete();
        done_seen = 1'b0;
        m_chk     = '0;
        for (int i = 0; i < int'(n); i++) begin
            e.re   = mem_r[4'(int'(b) + i)];
            e.im   = mem_i[4'(int'(b) + i)];
            e.last = (i == int'(n) - 1);
            exp_q.push_back(e);
        end
        if (n == 0) begin
            m_done_cyc  = s + 2;
            m_busy_from = -1;
        end else begin
            m_done_cyc  = -1;
            m_busy_from = s + 1;
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 300 && !done_seen; k++) tick();
        if (!done_seen) chk(1'b0, {name, "_done_timeout"}, 32'd0, 32'd1);
        tick();
    endtask

    int s;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        count     = '0;
        load_ramp();
        repeat (3) tick();
        @(negedge clk);
        chk(ram_addr == 0 && out_valid == 0 && out_last == 0, "reset_ctrl", 32'({ram_addr, out_valid, out_last}), 32'd0);
        chk(out_real == 0 && out_imag == 0, "reset_data", out_real | out_imag, 32'd0);
        chk(busy == 0 && done == 0, "reset_status", 32'({busy, done}), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Ramp data, base 0, count 4, ready high
        launch(4'd0, 5'd4, s);
        wait_done("s1");
        chk(log_cyc.size() == 4, "s1_beat_count", 32'(log_cyc.size()), 32'd4);
        if (log_cyc.size() == 4) begin
            chk(log_cyc[0] - s == 2, "s1_first_valid_delay", 32'(log_cyc[0] - s), 32'd2);
            chk(log_cyc[3] - s == 5, "s1_back_to_back", 32'(log_cyc[3] - s), 32'd5);
            chk(log_re[1] == 32'h0020_0000, "s1_beat1_real", log_re[1], 32'h0020_0000);
            chk(log_im[1] == 32'hFFE0_0000, "s1_beat1_imag", log_im[1], 32'hFFE0_0000);
            chk(log_re[3] == 32'h0060_0000, "s1_beat3_real", log_re[3], 32'h0060_0000);
        end
        chk(done_seen_cyc - s == 6, "s1_done_delay", 32'(done_seen_cyc - s), 32'd6);
        tick();

        // Address wrap: base 14, count 4
        addr_log.delete();
        trace_on = 1'b1;
        launch(4'd14, 5'd4, s);
        wait_done("s2");
        trace_on = 1'b0;
        chk(addr_log.size() == 4, "s2_addr_count", 32'(addr_log.size()), 32'd4);
        if (addr_log.size() == 4) begin
            chk(addr_log[0] == 4'd14 && addr_log[1] == 4'd15 && addr_log[2] == 4'd0 && addr_log[3] == 4'd1,
                "s2_addr_seq", 32'({addr_log[0], addr_log[1], addr_log[2], addr_log[3]}), 32'hEF01);
        end
        if (log_re.size() == 4) begin
            chk(log_re[0] == 32'h01C0_0000, "s2_beat0_real", log_re[0], 32'h01C0_0000);
            chk(log_im[1] == 32'hFE20_0000, "s2_beat1_imag", log_im[1], 32'hFE20_0000);
            chk(log_re[2] == 32'h0000_0000, "s2_beat2_real", log_re[2], 32'h0000_0000);
        end
        tick();

        // Arbitrary bit patterns with back-pressure
        for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] = $urandom;
            mem_i[i] = $urandom;
        end
        pat_base = cyc + 1;
        pat_mode = 1'b1;
        launch(4'd5, 5'd5, s);
        wait_done("s3");
        pat_mode = 1'b0;
        chk(log_re.size() == 5, "s3_beat_count", 32'(log_re.size()), 32'd5);
        tick();

        // count = 0
        launch(4'd3, 5'd0, s);
        wait_done("s4");
        chk(done_seen_cyc - s == 2, "s4_done_delay", 32'(done_seen_cyc - s), 32'd2);
        chk(log_re.size() == 0, "s4_no_beats", 32'(log_re.size()), 32'd0);
        tick();

        // Reset after two beats, then restart with count 3
        load_ramp();
        launch(4'd0, 5'd8, s);
        for (int k = 0; k < 50 && log_re.size() < 2; k++) tick();
        chk(log_re.size() >= 2, "s5_two_beats", 32'(log_re.size()), 32'd2);
        rst = 1'b1;
        exp_q.delete();
        m_done_cyc  = -1;
        m_busy_from = -1;
        m_busy      = 1'b0;
        done_seen   = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk(out_valid == 0 && out_last == 0 && ram_addr == 0, "s5_reset_ctrl", 32'({ram_addr, out_valid, out_last}), 32'd0);
        chk(out_real == 0 && out_imag == 0, "s5_reset_data", out_real | out_imag, 32'd0);
        chk(busy == 0 && done == 0, "s5_reset_status", 32'({busy, done}), 32'd0);
        repeat (6) tick();
        chk(!done_seen, "s5_no_abort_done", 32'(done_seen), 32'd0);
        launch(4'd6, 5'd3, s);
        wait_done("s5");
        chk(log_re.size() == 3, "s5_beat_count", 32'(log_re.size()), 32'd3);
        if (log_re.size() == 3)
            chk(log_re[0] == 32'h00C0_0000, "s5_beat0_real", log_re[0], 32'h00C0_0000);
        tick();

        // Ramp again with a start pulse while busy
        launch(4'd0, 5'd4, s);
        start     = 1'b1;
        base_addr = 4'd9;
        count     = 5'd2;
        tick();
        start = 1'b0;
        wait_done("s6");
        chk(log_re.size() == 4, "s6_beat_count", 32'(log_re.size()), 32'd4);
        chk(done_seen_cyc - s == 6, "s6_done_delay", 32'(done_seen_cyc - s), 32'd6);
`ifdef READER_CHKSUM_EN
        chk(chksum == 32'hFF80_0000, "s6_chksum", chksum, 32'hFF80_0000);
        repeat (2) tick();
        chk(chksum == 32'hFF80_0000, "s6_chksum_held", chksum, 32'hFF80_0000);
`endif
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
